// File: rtl/otbn_pq_pkg.sv
// Shared types for the PQ_ALU NTT index generator: FSM state encoding, minimum legal log2(N),
// and the default-width tuple layout presented to the bit-reverse stage.
package otbn_pq_pkg;

   localparam int IdxLogNMin        = 6;
   localparam int IdxLogNMaxDefault = 12;

   typedef enum logic [1:0] {
      IdxIdle = 2'd0,
      IdxRun  = 2'd1,
      IdxDone = 2'd2
   } idx_gen_state_e;

   typedef struct packed {
      logic [IdxLogNMaxDefault-1:0] idx_a;
      logic [IdxLogNMaxDefault-1:0] idx_b;
      logic [IdxLogNMaxDefault-1:0] twiddle_k;
      logic [3:0]                   nof_bits;
      logic                         last;
   } ntt_idx_tuple_t;

endpackage

// File: rtl/ntt_index_counter.sv
// Nested len/start/j counter that walks one NTT loop nest; presents the successor position and
// whether that successor is the final butterfly of the transform.
// Latency: combinational successor, state advances on load/adv. No backpressure of its own.
module ntt_index_counter #(
   parameter int LogNMax = 12
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic               adv_i,
   input  logic               inverse_i,
   input  logic [3:0]         log_n_i,
   input  logic [3:0]         min_len_log_i,
   output logic [3:0]         nxt_len_log_o,
   output logic [LogNMax-1:0] nxt_start_o,
   output logic [LogNMax-1:0] nxt_j_o,
   output logic               grp_end_o,
   output logic               nxt_last_o
);

   localparam int W = LogNMax + 1;

   logic [3:0]         r_len_log;
   logic [LogNMax-1:0] r_start;
   logic [LogNMax-1:0] r_j;

   logic [W-1:0] w_n;
   logic [W-1:0] w_len;
   logic [W-1:0] w_span;
   logic [W-1:0] w_nxt_len;
   logic         w_layer_end;
   logic [3:0]   w_fin_log;

   // N itself needs one bit more than any index, hence the W-bit arithmetic
   assign w_n         = W'(1) << log_n_i;
   assign w_len       = W'(1) << r_len_log;
   assign w_span      = w_len << 1;
   assign grp_end_o   = ({1'b0, r_j} == (w_len - W'(1)));
   assign w_layer_end = (({1'b0, r_start} + w_span) == w_n);
   assign w_fin_log   = inverse_i ? (log_n_i - 4'd1) : min_len_log_i;

   always_comb begin
      nxt_len_log_o = r_len_log;
      nxt_start_o   = r_start;
      nxt_j_o       = r_j;
      if (load_i) begin
         nxt_len_log_o = inverse_i ? min_len_log_i : (log_n_i - 4'd1);
         nxt_start_o   = '0;
         nxt_j_o       = '0;
      end else if (adv_i) begin
         if (!grp_end_o) begin
            nxt_j_o = r_j + LogNMax'(1);
         end else begin
            nxt_j_o = '0;
            if (!w_layer_end) begin
               nxt_start_o = r_start + w_span[LogNMax-1:0];
            end else begin
               nxt_start_o   = '0;
               nxt_len_log_o = inverse_i ? (r_len_log + 4'd1) : (r_len_log - 4'd1);
            end
         end
      end
   end

   assign w_nxt_len  = W'(1) << nxt_len_log_o;
   assign nxt_last_o = (nxt_len_log_o == w_fin_log) &&
                       ({1'b0, nxt_j_o} == (w_nxt_len - W'(1))) &&
                       (({1'b0, nxt_start_o} + (w_nxt_len << 1)) == w_n);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_len_log <= '0;
         r_start   <= '0;
         r_j       <= '0;
      end else begin
         r_len_log <= nxt_len_log_o;
         r_start   <= nxt_start_o;
         r_j       <= nxt_j_o;
      end
   end

endmodule

// File: rtl/ntt_index_gen.sv
// NTT/INTT butterfly index generator (CT forward / GS inverse); optional OTBN_PQ_IDX_GEN_LAYER_LIMIT_EN.
// Latency: start accepted at t -> first tuple at t+1, then one tuple per cycle at full throughput.
// Backpressure: valid/ready; all outputs hold while valid_o & !ready_i.
module ntt_index_gen
   import otbn_pq_pkg::*;
#(
   parameter int LogNMax = 12
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               clear_i,
   input  logic               inverse_i,
   input  logic [3:0]         log_n_i,
`ifdef OTBN_PQ_IDX_GEN_LAYER_LIMIT_EN
   input  logic [3:0]         min_len_log_i,
`endif
   output logic               valid_o,
   input  logic               ready_i,
   output logic [LogNMax-1:0] idx_a_o,
   output logic [LogNMax-1:0] idx_b_o,
   output logic [LogNMax-1:0] twiddle_k_o,
   output logic [3:0]         nof_bits_o,
   output logic               last_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o
);

   localparam int W = LogNMax + 1;
   localparam logic [1:0] StIdle = 2'(IdxIdle);
   localparam logic [1:0] StRun  = 2'(IdxRun);
   localparam logic [1:0] StDone = 2'(IdxDone);

   logic [1:0]         r_state;
   logic               r_inverse;
   logic [3:0]         r_log_n;
   logic               r_valid;
   logic [LogNMax-1:0] r_idx_a;
   logic [LogNMax-1:0] r_idx_b;
   logic [LogNMax-1:0] r_k;
   logic [3:0]         r_nof_bits;
   logic               r_last;
   logic               r_done;
   logic               r_err;

   logic               w_idle, w_legal, w_load, w_xfer, w_adv;
   logic               w_cfg_inverse;
   logic [3:0]         w_cfg_log_n, w_cfg_min;
   logic [W-1:0]       w_n;
   logic [LogNMax-1:0] w_k0, w_k_nxt, w_nxt_a, w_nxt_b;
   logic [3:0]         w_nxt_len_log;
   logic [LogNMax-1:0] w_nxt_start, w_nxt_j;
   logic               w_grp_end, w_nxt_last;

   assign w_idle = (r_state == StIdle);

`ifdef OTBN_PQ_IDX_GEN_LAYER_LIMIT_EN
   logic [3:0] r_min_len_log;
   assign w_cfg_min = w_idle ? min_len_log_i : r_min_len_log;
   assign w_legal   = (log_n_i >= 4'(IdxLogNMin)) && (log_n_i <= 4'(LogNMax)) &&
                      (min_len_log_i < log_n_i);
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       r_min_len_log <= '0;
      else if (w_load) r_min_len_log <= min_len_log_i;
   end
`else
   assign w_cfg_min = '0;
   assign w_legal   = (log_n_i >= 4'(IdxLogNMin)) && (log_n_i <= 4'(LogNMax));
`endif

   assign w_load        = w_idle && start_i && !clear_i && w_legal;
   assign w_xfer        = r_valid && ready_i && !clear_i;
   assign w_adv         = w_xfer && !r_last;
   assign w_cfg_inverse = w_idle ? inverse_i : r_inverse;
   assign w_cfg_log_n   = w_idle ? log_n_i : r_log_n;

   // inverse k starts where a full transform would be after skipping the layers below min_len
   assign w_n     = W'(1) << w_cfg_log_n;
   assign w_k0    = w_cfg_inverse ? LogNMax'((w_n >> w_cfg_min) - W'(1)) : LogNMax'(1);
   assign w_k_nxt = w_load    ? w_k0 :
                    w_grp_end ? (r_inverse ? (r_k - LogNMax'(1)) : (r_k + LogNMax'(1))) : r_k;
   assign w_nxt_a = w_nxt_start + w_nxt_j;
   assign w_nxt_b = w_nxt_a + LogNMax'(W'(1) << w_nxt_len_log);

   ntt_index_counter #(
      .LogNMax (LogNMax)
   ) u_counter (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .load_i        (w_load),
      .adv_i         (w_adv),
      .inverse_i     (w_cfg_inverse),
      .log_n_i       (w_cfg_log_n),
      .min_len_log_i (w_cfg_min),
      .nxt_len_log_o (w_nxt_len_log),
      .nxt_start_o   (w_nxt_start),
      .nxt_j_o       (w_nxt_j),
      .grp_end_o     (w_grp_end),
      .nxt_last_o    (w_nxt_last)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= StIdle;
         r_inverse  <= 1'b0;
         r_log_n    <= '0;
         r_valid    <= 1'b0;
         r_idx_a    <= '0;
         r_idx_b    <= '0;
         r_k        <= '0;
         r_nof_bits <= '0;
         r_last     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else if (clear_i) begin
         r_state <= StIdle;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            StIdle: begin
               if (start_i && w_legal) begin
                  r_state    <= StRun;
                  r_valid    <= 1'b1;
                  r_inverse  <= inverse_i;
                  r_log_n    <= log_n_i;
                  r_nof_bits <= log_n_i;
               end else if (start_i) begin
                  r_err <= 1'b1;
               end
            end
            StRun: begin
               if (w_xfer && r_last) begin
                  r_state <= StDone;
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
         if (w_load || w_adv) begin
            r_idx_a <= w_nxt_a;
            r_idx_b <= w_nxt_b;
            r_k     <= w_k_nxt;
            r_last  <= w_nxt_last;
         end
      end
   end

   assign valid_o     = r_valid;
   assign idx_a_o     = r_idx_a;
   assign idx_b_o     = r_idx_b;
   assign twiddle_k_o = r_k;
   assign nof_bits_o  = r_nof_bits;
   assign last_o      = r_last;
   assign busy_o      = (r_state != StIdle);
   assign done_o      = r_done;
   assign err_o       = r_err;

endmodule
